ram_dp_byte_enable: RTL and testbench

//   Simple dual-port synchronous RAM: one write port and one independent read port.
//   It supersedes the single-port RAM with per-byte write enables and a selectable

---
 rtl/ram_dp_byte_enable.sv | 133 +++++++++++++
 tb/tb_ram_dp_byte_enable.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/ram_dp_byte_enable.sv
// Simple dual-port RAM with per-byte write enables, 1- or 2-clock registered read,
// selectable read-during-write behaviour and an optional post-reset clear sequencer.
module ram_dp_byte_enable #(
    parameter int unsigned ADDRESS_WIDTH  = 4,
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned READ_LATENCY   = 1,
    parameter int unsigned WRITE_FIRST    = 0,
    parameter int unsigned CLEAR_ON_RESET = 1
) (
    input  logic                      Clock,
    input  logic                      Reset,
    output logic                      Ready_o,
    input  logic                      WriteEnable_i,
    input  logic [ADDRESS_WIDTH-1:0]  WriteAddress_i,
    input  logic [DATA_WIDTH/8-1:0]   ByteEnable_i,
    input  logic [DATA_WIDTH-1:0]     Data_i,
    input  logic                      ReadEnable_i,
    input  logic [ADDRESS_WIDTH-1:0]  ReadAddress_i,
    output logic [DATA_WIDTH-1:0]     Data_o,
    output logic                      DataValid_o
);

    localparam int unsigned DEPTH = 1 << ADDRESS_WIDTH;
    localparam int unsigned LANES = DATA_WIDTH / 8;
    localparam logic [ADDRESS_WIDTH:0] CLEAR_LAST = (ADDRESS_WIDTH + 1)'(DEPTH - 1);

    localparam logic ST_CLEAR = 1'b0;
    localparam logic ST_READY = 1'b1;
    localparam logic ST_INIT  = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;

    logic [DATA_WIDTH-1:0]  r_mem [DEPTH];
    logic                   r_state;
    logic                   r_ready;
    logic [ADDRESS_WIDTH:0] r_clear_cnt;
    logic                   r_valid;
    logic [DATA_WIDTH-1:0]  r_data;

    logic                   w_clear_we;
    logic                   w_wr_accept;
    logic                   w_rd_accept;
    logic [DATA_WIDTH-1:0]  w_wr_merged;
    logic [DATA_WIDTH-1:0]  w_rd_word;
    logic                   w_out_valid;
    logic [DATA_WIDTH-1:0]  w_out_data;

    assign w_clear_we  = (r_state == ST_CLEAR);
    assign w_wr_accept = WriteEnable_i && r_ready;
    assign w_rd_accept = ReadEnable_i && r_ready;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_state     <= ST_INIT;
            r_ready     <= 1'b0;
            r_clear_cnt <= '0;
        end else if (r_state == ST_CLEAR) begin
            r_clear_cnt <= r_clear_cnt + 1'b1;
            if (r_clear_cnt == CLEAR_LAST) begin
                r_state <= ST_READY;
                r_ready <= 1'b1;
            end
        end else begin
            r_ready <= 1'b1;
        end
    end

    always_comb begin
        w_wr_merged = r_mem[WriteAddress_i];
        for (int k = 0; k < LANES; k++) begin
            if (ByteEnable_i[k]) begin
                w_wr_merged[8*k +: 8] = Data_i[8*k +: 8];
            end
        end
    end

    // Array has no reset; only the clear sequencer or accepted writes change it.
    always_ff @(posedge Clock) begin
        if (w_clear_we) begin
            r_mem[r_clear_cnt[ADDRESS_WIDTH-1:0]] <= '0;
        end else if (w_wr_accept) begin
            r_mem[WriteAddress_i] <= w_wr_merged;
        end
    end

    always_comb begin
        w_rd_word = r_mem[ReadAddress_i];
        if ((WRITE_FIRST != 0) && w_wr_accept && (WriteAddress_i == ReadAddress_i)) begin
            w_rd_word = w_wr_merged;
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic                  r_s1_valid;
            logic [DATA_WIDTH-1:0] r_s1_data;

            always_ff @(posedge Clock or negedge Reset) begin
                if (!Reset) begin
                    r_s1_valid <= 1'b0;
                    r_s1_data  <= '0;
                end else begin
                    r_s1_valid <= w_rd_accept;
                    if (w_rd_accept) begin
                        r_s1_data <= w_rd_word;
                    end
                end
            end

            assign w_out_valid = r_s1_valid;
            assign w_out_data  = r_s1_data;
        end else begin : g_lat1
            assign w_out_valid = w_rd_accept;
            assign w_out_data  = w_rd_word;
        end
    endgenerate

    // Data_o holds its last value when no result is due.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            r_valid <= w_out_valid;
            if (w_out_valid) begin
                r_data <= w_out_data;
            end
        end
    end

    assign Ready_o     = r_ready;
    assign DataValid_o = r_valid;
    assign Data_o      = r_data;

endmodule

// File: tb/tb_ram_dp_byte_enable.sv
// Bench for ram_dp_byte_enable: three configurations share one stimulus stream and are
// compared every edge against an array/queue reference model.
module tb_ram_dp_byte_enable;

    localparam int AW = 4;
    localparam int DW = 16;
    localparam int NW = 1 << AW;

    typedef struct {
        int          due;
        logic [15:0] data;
        logic [15:0] mask;
    } exp_t;

    logic        Clock;
    logic        Reset;
    logic        WriteEnable_i;
    logic [3:0]  WriteAddress_i;
    logic [1:0]  ByteEnable_i;
    logic [15:0] Data_i;
    logic        ReadEnable_i;
    logic [3:0]  ReadAddress_i;

    logic        rdy [3];
    logic        vld [3];
    logic [15:0] dat [3];

    int checks   = 0;
    int failures = 0;

    logic [15:0] mem_a   [NW];
    logic [15:0] mem_b   [NW];
    logic [15:0] known_b [NW];
    exp_t        q [3][$];
    logic [15:0] last_data [3];
    logic [15:0] last_mask [3];
    int          lat  [3] = '{1, 2, 1};
    int          need [3] = '{NW, NW, 1};
    int          since_rel = 0;
    int          edge_no   = 0;

    ram_dp_byte_enable #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(1),
        .WRITE_FIRST(0), .CLEAR_ON_RESET(1)) u0 (
        .Clock(Clock), .Reset(Reset), .Ready_o(rdy[0]), .WriteEnable_i(WriteEnable_i),
        .WriteAddress_i(WriteAddress_i), .ByteEnable_i(ByteEnable_i), .Data_i(Data_i),
        .ReadEnable_i(ReadEnable_i), .ReadAddress_i(ReadAddress_i), .Data_o(dat[0]),
        .DataValid_o(vld[0]));

    ram_dp_byte_enable #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(2),
        .WRITE_FIRST(1), .CLEAR_ON_RESET(1)) u1 (
        .Clock(Clock), .Reset(Reset), .Ready_o(rdy[1]), .WriteEnable_i(WriteEnable_i),
        .WriteAddress_i(WriteAddress_i), .ByteEnable_i(ByteEnable_i), .Data_i(Data_i),
        .ReadEnable_i(ReadEnable_i), .ReadAddress_i(ReadAddress_i), .Data_o(dat[1]),
        .DataValid_o(vld[1]));

    ram_dp_byte_enable #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(1),
        .WRITE_FIRST(0), .CLEAR_ON_RESET(0)) u2 (
        .Clock(Clock), .Reset(Reset), .Ready_o(rdy[2]), .WriteEnable_i(WriteEnable_i),
        .WriteAddress_i(WriteAddress_i), .ByteEnable_i(ByteEnable_i), .Data_i(Data_i),
        .ReadEnable_i(ReadEnable_i), .ReadAddress_i(ReadAddress_i), .Data_o(dat[2]),
        .DataValid_o(vld[2]));

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] nw,
                                          input logic [1:0] be);
        logic [15:0] m;
        m = old;
        if (be[0]) m[7:0]  = nw[7:0];
        if (be[1]) m[15:8] = nw[15:8];
        return m;
    endfunction

    task automatic tick(input logic we, input logic [3:0] wa, input logic [1:0] be,
                        input logic [15:0] wd, input logic re, input logic [3:0] ra);
        logic        rdy_a, rdy_b;
        logic [15:0] new_a, ev_d, ev_m;
        logic        ev_v;
        exp_t        e;
        WriteEnable_i  = we;
        WriteAddress_i = wa;
        ByteEnable_i   = be;
        Data_i         = wd;
        ReadEnable_i   = re;
        ReadAddress_i  = ra;
        rdy_a = (since_rel >= NW);
        rdy_b = (since_rel >= 1);
        new_a = merge(mem_a[wa], wd, be);
        if (re && rdy_a) begin
            q[0].push_back('{edge_no + 1, mem_a[ra], 16'hFFFF});
            q[1].push_back('{edge_no + 2, (we && wa == ra) ? new_a : mem_a[ra], 16'hFFFF});
        end
        if (re && rdy_b) q[2].push_back('{edge_no + 1, mem_b[ra], known_b[ra]});
        @(posedge Clock);
        #1;
        edge_no++;
        since_rel++;
        if (we && rdy_a) mem_a[wa] = new_a;
        if (we && rdy_b) begin
            mem_b[wa]   = merge(mem_b[wa], wd, be);
            known_b[wa] = known_b[wa] | {{8{be[1]}}, {8{be[0]}}};
        end
        for (int i = 0; i < 3; i++) begin
            ev_v = 1'b0;
            ev_d = last_data[i];
            ev_m = last_mask[i];
            if (q[i].size() > 0 && q[i][0].due == edge_no) begin
                e = q[i].pop_front();
                ev_v = 1'b1;
                ev_d = e.data;
                ev_m = e.mask;
                last_data[i] = e.data;
                last_mask[i] = e.mask;
            end
            chk($sformatf("ready%0d@%0d", i, edge_no), 16'(rdy[i]), 16'(since_rel >= need[i]));
            chk($sformatf("valid%0d@%0d", i, edge_no), 16'(vld[i]), 16'(ev_v));
            chk($sformatf("data%0d@%0d", i, edge_no), dat[i] & ev_m, ev_d & ev_m);
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick(1'b0, 4'h0, 2'b00, 16'h0000, 1'b0, 4'h0);
    endtask

    // Asserts Reset away from the edge, checks the asynchronous effect, then releases.
    task automatic apply_reset(input int hold);
        #2;
        Reset = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_ready%0d", i), 16'(rdy[i]), 16'h0000);
            chk($sformatf("rst_valid%0d", i), 16'(vld[i]), 16'h0000);
            chk($sformatf("rst_data%0d", i), dat[i], 16'h0000);
            q[i].delete();
            last_data[i] = 16'h0000;
            last_mask[i] = 16'hFFFF;
        end
        for (int a = 0; a < NW; a++) mem_a[a] = 16'h0000;
        repeat (hold) @(posedge Clock);
        #1;
        Reset = 1'b1;
        since_rel = 0;
    endtask

    initial begin
        logic        r_we, r_re;
        logic [3:0]  r_wa, r_ra;
        logic [1:0]  r_be;
        logic [15:0] r_wd;
        Reset = 1'b0;
        WriteEnable_i = 1'b0;
        WriteAddress_i = '0;
        ByteEnable_i = '0;
        Data_i = '0;
        ReadEnable_i = 1'b0;
        ReadAddress_i = '0;
        for (int a = 0; a < NW; a++) begin
            mem_b[a]   = 16'h0000;
            known_b[a] = 16'h0000;
        end
        @(posedge Clock);
        #1;
        apply_reset(3);

        // Clear phase: write and read requests must be ignored by the clearing instances.
        tick(1'b0, 4'h0, 2'b00, 16'h0000, 1'b1, 4'h2);
        tick(1'b1, 4'hF, 2'b01, 16'h0055, 1'b0, 4'h0);
        idle(NW - 2);
        for (int a = 0; a < NW; a++) tick(1'b0, 4'h0, 2'b00, 16'h0000, 1'b1, 4'(a));
        chk("clear_read_0F", dat[0], 16'h0000);
        idle(2);

        tick(1'b1, 4'hA, 2'b01, 16'h00AA, 1'b0, 4'h0);
        tick(1'b1, 4'h3, 2'b01, 16'h0033, 1'b0, 4'h0);
        for (int a = 0; a < NW; a++) tick(1'b0, 4'h0, 2'b00, 16'h0000, 1'b1, 4'(a));
        idle(2);

        tick(1'b1, 4'h5, 2'b11, 16'hBEEF, 1'b0, 4'h0);
        tick(1'b1, 4'h5, 2'b10, 16'h1234, 1'b0, 4'h0);
        tick(1'b0, 4'h0, 2'b00, 16'h0000, 1'b1, 4'h5);
        chk("byte_merge_05", dat[0], 16'h12EF);

        tick(1'b1, 4'h7, 2'b11, 16'h0011, 1'b0, 4'h0);
        tick(1'b1, 4'h7, 2'b01, 16'h0022, 1'b1, 4'h7);
        chk("collision_read_first", dat[0], 16'h0011);
        idle(1);
        chk("collision_write_first", dat[1], 16'h0022);
        idle(1);

        for (int n = 0; n < 300; n++) begin
            r_we = 1'($urandom_range(0, 1));
            r_re = 1'($urandom_range(0, 1));
            r_wa = 4'($urandom_range(0, NW - 1));
            r_ra = ($urandom_range(0, 3) == 0) ? r_wa : 4'($urandom_range(0, NW - 1));
            r_be = 2'($urandom_range(0, 3));
            r_wd = 16'($urandom);
            tick(r_we, r_wa, r_be, r_wd, r_re, r_ra);
        end

        // Reset with a read in flight, then again partway through the clear.
        tick(1'b0, 4'h0, 2'b00, 16'h0000, 1'b1, 4'h3);
        apply_reset(2);
        idle(5);
        apply_reset(1);
        idle(NW + 1);
        for (int n = 0; n < 150; n++) begin
            r_we = 1'($urandom_range(0, 1));
            r_re = 1'($urandom_range(0, 1));
            r_wa = 4'($urandom_range(0, NW - 1));
            r_ra = ($urandom_range(0, 3) == 0) ? r_wa : 4'($urandom_range(0, NW - 1));
            r_be = 2'($urandom_range(0, 3));
            r_wd = 16'($urandom);
            tick(r_we, r_wa, r_be, r_wd, r_re, r_ra);
        end
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
